// File: rtl/rx_deint_ctrl_wifi_pkg.sv
// Shared WIFI PHY constants: OFDM block length and controller state encoding.
package rx_deint_ctrl_wifi_pkg;

    localparam int NCBPS_WIFI = 192;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

endpackage

// File: rtl/rx_deint_ctrl_wifi.sv
// Sequencer that fills the external deinterleaver one OFDM symbol at a time and
// drains it, counting symbols per packet and flagging protocol/timeout errors.
//
// state  | meaning
// IDLE   | waiting for start
// FILL   | accepting NCBPS coded bits from the demapper
// LAUNCH | one cycle with the deinterleaver frozen so the block is not overwritten
// DRAIN  | deinterleaver emits the block; counted and timed
// NEXT   | symbol done; end the packet or refill
// ERR    | sticky error set, done pulsed, back to IDLE
module rx_deint_ctrl_wifi
    import rx_deint_ctrl_wifi_pkg::*;
#(
    parameter int NCBPS   = NCBPS_WIFI,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] num_symbols,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       deint_enable,
    output logic       deint_valid_in,
    input  logic       deint_finished,
    input  logic       deint_valid_out,
    output logic [7:0] sym_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      NCBPS_C    = 8'(NCBPS);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    bit_cnt_q, out_cnt_q, sym_count_q, num_sym_q;
    logic [TW-1:0] timer_q;
    logic          fin_low_q, error_q, zero_done_q;

    logic          proto_err, start_acc, last_sym;
    logic [7:0]    out_cnt_eff;

    assign proto_err   = deint_valid_out && (state_q != ST_DRAIN) && (state_q != ST_ERR);
    assign start_acc   = (state_q == ST_IDLE) && start && !proto_err;
    assign last_sym    = (sym_count_q + 8'd1) == num_sym_q;
    // Count a valid_out arriving in the same cycle as finished.
    assign out_cnt_eff = out_cnt_q + {7'd0, deint_valid_out && (out_cnt_q != NCBPS_C)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            out_cnt_q   <= '0;
            sym_count_q <= '0;
            num_sym_q   <= '0;
            timer_q     <= '0;
            fin_low_q   <= 1'b0;
            error_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= start_acc && (num_symbols == 8'd0);
            if (start_acc) begin
                num_sym_q   <= num_symbols;
                bit_cnt_q   <= '0;
                out_cnt_q   <= '0;
                sym_count_q <= '0;
                error_q     <= 1'b0;
            end
            if ((state_q == ST_FILL) && in_valid && (bit_cnt_q != NCBPS_C))
                bit_cnt_q <= bit_cnt_q + 8'd1;
            if (state_q == ST_LAUNCH) begin
                timer_q   <= '0;
                fin_low_q <= 1'b0;
            end
            if (state_q == ST_DRAIN) begin
                out_cnt_q <= out_cnt_eff;
                timer_q   <= timer_q + TIMER_ONE;
                if (!deint_finished)
                    fin_low_q <= 1'b1;
            end
            if (state_q == ST_NEXT) begin
                sym_count_q <= sym_count_q + 8'd1;
                if (!last_sym) begin
                    bit_cnt_q <= '0;
                    out_cnt_q <= '0;
                end
            end
            if ((state_d == ST_ERR) && (state_q != ST_ERR))
                error_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && (num_symbols != 8'd0)) state_d = ST_FILL;
            ST_FILL:   if (in_valid && (bit_cnt_q == NCBPS_C - 8'd1)) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_DRAIN;
            ST_DRAIN: begin
                // A finished level left over from the previous block is ignored until seen low.
                if (deint_finished && fin_low_q)
                    state_d = (out_cnt_eff == NCBPS_C) ? ST_NEXT : ST_ERR;
                else if (timer_q == TIMER_LAST)
                    state_d = ST_ERR;
            end
            ST_NEXT:   state_d = last_sym ? ST_IDLE : ST_FILL;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (proto_err)
            state_d = ST_ERR;
    end

    always_comb begin
        in_ready       = 1'b0;
        deint_enable   = 1'b0;
        deint_valid_in = 1'b0;
        done           = zero_done_q;
        case (state_q)
            ST_FILL: begin
                in_ready       = 1'b1;
                deint_enable   = 1'b1;
                deint_valid_in = in_valid;
            end
            ST_DRAIN: deint_enable = 1'b1;
            ST_NEXT:  done = zero_done_q | last_sym;
            ST_ERR:   done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = state_q != ST_IDLE;
    assign sym_count = sym_count_q;
    assign error     = error_q;

endmodule

// File: doc/rx_deint_ctrl_wifi.md
RX_DEINT_CTRL_WIFI -- requirements
Module: rx_deint_ctrl_wifi

Interface
REQ-001 Parameter NCBPS, default 192: coded bits per OFDM symbol, the block length of the deinterleaver.
REQ-002 Parameter TIMEOUT, default 1023: maximum number of cycles allowed in a drain phase.
REQ-003 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port start, input, 1: one-cycle pulse that starts a packet; it is ignored unless the state is IDLE.
REQ-006 Port num_symbols, input, 8: symbols in the packet; it is sampled on the accepted start.
REQ-007 Port in_valid, input, 1: bit-valid from the demapper.
REQ-008 Port in_ready, output, 1: demapper may present a bit.
REQ-009 Port deint_enable, output, 1: enable to the deinterleaver.
REQ-010 Port deint_valid_in, output, 1: valid_in to the deinterleaver.
REQ-011 Port deint_finished, input, 1: finished from the deinterleaver.
REQ-012 Port deint_valid_out, input, 1: valid_out from the deinterleaver.
REQ-013 Port sym_count, output, 8: symbols completed in the current packet.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port done, output, 1: one-cycle pulse at the end of a packet.
REQ-016 Port error, output, 1: sticky flag, cleared by the next accepted start.

Function
REQ-017 States are IDLE, FILL, LAUNCH, DRAIN, NEXT and ERR.
REQ-018 IDLE with start=1 and num_symbols!=0 goes to FILL and clears bit_cnt, out_cnt, sym_count and error.
REQ-019 IDLE with start=1 and num_symbols=0 gives a done pulse the next cycle and stays in IDLE.
REQ-020 FILL behaviour:
- in_ready=1 and deint_enable=1.
- deint_valid_in = in_valid, combinational pass-through.
- bit_cnt increments on each in_valid.
- On the cycle where bit_cnt=NCBPS-1 and in_valid=1, go to LAUNCH.
REQ-021 LAUNCH lasts one cycle:
- in_ready=0 and deint_valid_in=0.
- deint_enable=0, so the deinterleaver cannot overwrite the block.
- Go to DRAIN and clear the timer.
REQ-022 DRAIN behaviour:
- deint_enable=1, deint_valid_in=0, in_ready=0.
- out_cnt increments on each deint_valid_out.
- The timer increments every cycle.
REQ-023 DRAIN exits to NEXT when deint_finished=1 on a cycle after it has been seen low, provided out_cnt=NCBPS.
REQ-024 If deint_finished rises with out_cnt!=NCBPS, or the timer reaches TIMEOUT, go to ERR.
REQ-025 NEXT lasts one cycle:
- sym_count increments.
- If the new sym_count equals num_symbols, pulse done and go to IDLE.
- Otherwise clear bit_cnt and out_cnt and go to FILL.
REQ-026 ERR sets error=1, pulses done and returns to IDLE on the next cycle.
REQ-027 bit_cnt and out_cnt are 8 bits wide and saturate at NCBPS.
REQ-028 A deint_valid_out outside DRAIN is counted as a protocol error and drives the state to ERR.
REQ-029 If start and reset are asserted in the same cycle, reset wins.
REQ-030 in_valid while in_ready=0 is dropped and has no effect on any counter.

Reset
REQ-031 On reset=1 at a clock edge the state becomes IDLE.
REQ-032 On reset the counters become 0.
REQ-033 On reset every output is 0: in_ready, deint_enable, deint_valid_in, busy, done, error, sym_count.
REQ-034 Reset asserted mid-packet aborts the packet immediately with no done pulse.

Structure
REQ-035 NCBPS_WIFI=192 and the state encoding (3-bit localparams) are defined in the shared WIFI PHY constants package.
REQ-036 The block is a single module with no sub-modules.
REQ-037 The deinterleaver is instantiated beside this block, not inside it.

Verification
REQ-038 Normal packet:
- Stimulus: start with num_symbols=2, 192 contiguous in_valid per symbol, deinterleaver model.
- Response: exactly 384 deint_valid_in pulses, sym_count reaches 2, one done, error=0.
REQ-039 Gapped input:
- Stimulus: in_valid toggling 1/0.
- Response: LAUNCH is entered exactly after the 192nd valid bit, and in_ready drops the cycle after.
REQ-040 Timeout:
- Stimulus: the model never raises deint_finished.
- Response: the state is ERR at TIMEOUT cycles, error=1, one done pulse.
- Check: the next start clears error.
REQ-041 Short drain:
- Stimulus: the model gives 191 valid_out and then finished=1.
- Response: error=1, sym_count unchanged.
REQ-042 Reset mid-operation:
- Stimulus: reset during DRAIN of symbol 1 of 3.
- Response: all outputs are 0 next cycle, no done, and a new start works normally.
REQ-043 Zero-length packet:
- Stimulus: num_symbols=0.
- Response: done one cycle after start, busy stays 0, no deint_valid_in.
